bram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port SoC block RAM. The BRAM has one-cycle registered read latency and byte-masked writes.
- Requester 0 is the CPU memory port. Requester 1 is the boot loader/debug port.
- The block accepts one transaction at a time, drives the BRAM bus, captures the read word and returns a one-cycle response pulse to the granted requester.
- It also flags accesses outside the BRAM window.

---
 rtl/bram_arbiter.sv | 154 +++++++++++++++
 tb/tb_bram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port BRAM with
// one-cycle registered reads and byte-masked writes.

module bram_arbiter_port #(
    parameter logic ID = 1'b0
) (
    input  logic        grant_any,
    input  logic        win,
    input  logic        resp,
    input  logic        lat_id,
    input  logic        lat_we,
    input  logic        in_range,
    input  logic [31:0] mem_rdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);
    assign gnt    = grant_any && (win == ID);
    assign rvalid = resp && (lat_id == ID);
    // Only an in-range read forwards the BRAM bus; everything else returns zero.
    assign rdata  = (rvalid && !lat_we && in_range) ? mem_rdata : 32'h0;
    assign err    = rvalid && !in_range;
endmodule

module bram_arbiter #(
    parameter logic [31:0] BASE_MEMORY    = 32'h0000_0000,
    parameter logic [31:0] TOP_MEMORY     = 32'h0000_01ff,
    parameter logic        FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [3:0]  m0_mask,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [3:0]  m1_mask,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
        logic        id;
    } req_t;

    state_t          state, state_n;
    req_t            lat;
    req_t [1:0]      fld;
    logic [1:0]      req;
    logic            last_grant;
    logic            grant_any, win;
    logic            in_range, resp;
    logic [32:0]     lo_diff, hi_diff;
    logic [1:0]      gnt, rvalid, err;
    logic [1:0][31:0] rdata;

    assign req    = {m1_req, m0_req};
    assign fld[0] = {m0_addr, m0_wdata, m0_we, m0_mask, 1'b0};
    assign fld[1] = {m1_addr, m1_wdata, m1_we, m1_mask, 1'b1};

    always_comb begin
        state_n   = state;
        grant_any = 1'b0;
        if (req == 2'b11)
            win = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        else
            win = req[1];
        case (state)
            IDLE, RESP: begin
                if (|req) begin
                    grant_any = !reset;
                    state_n   = ACCESS;
                end else begin
                    state_n   = IDLE;
                end
            end
            ACCESS:  state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat        <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_n;
            // The latch only loads on a grant, so the BRAM bus changes on
            // entry to ACCESS and holds its last value everywhere else.
            if (grant_any) begin
                lat        <= fld[win];
                last_grant <= win;
            end
        end
    end

    // Borrow-based unsigned window test avoids constant-compare edge cases.
    assign lo_diff  = {1'b0, lat.addr} - {1'b0, BASE_MEMORY};
    assign hi_diff  = {1'b0, TOP_MEMORY} - {1'b0, lat.addr};
    assign in_range = !lo_diff[32] && !hi_diff[32];
    assign resp     = (state == RESP) && !reset;

    assign mem_addr  = lat.addr;
    assign mem_wdata = lat.wdata;
    assign mem_mask  = lat.mask;
    assign mem_write = (state == ACCESS) && lat.we && in_range && !reset;

    for (genvar i = 0; i < 2; i++) begin : g_port
        bram_arbiter_port #(.ID(1'(i))) u_port (
            .grant_any (grant_any),
            .win       (win),
            .resp      (resp),
            .lat_id    (lat.id),
            .lat_we    (lat.we),
            .in_range  (in_range),
            .mem_rdata (mem_rdata),
            .gnt       (gnt[i]),
            .rvalid    (rvalid[i]),
            .rdata     (rdata[i]),
            .err       (err[i])
        );
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];
    assign m0_err    = err[0];
    assign m1_err    = err[1];
endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: BRAM model, reference memory, and a
// fixed-priority instance for the tie-break checks.

module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  freq = '0;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        we [2];
    logic [3:0]  mask [2];
    logic [1:0]  gnt, rvalid, err;
    logic [31:0] rdata [2];
    logic [1:0]  fgnt, frvalid, ferr;
    logic [31:0] frdata [2];
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;
    logic [3:0]  mem_mask;
    logic [31:0] fmem_addr, fmem_wdata;
    logic        fmem_write;
    logic [3:0]  fmem_mask;
    logic [31:0] fmem_rdata = 32'h0;

    logic [31:0] bram [128];
    logic [31:0] ref_mem [128];

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
    } ent_t;
    ent_t sb[$];
    int   glog[$];

    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, nwr = 0;
    int          fn0 = 0, fn1 = 0, frv0 = 0, frv1 = 0;
    logic [31:0] last_rdata = '0, last_waddr = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    bram_arbiter #(.FIXED_PRIORITY(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_we(we[0]), .m0_mask(mask[0]),
        .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
        .m1_req(req[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_we(we[1]), .m1_mask(mask[1]),
        .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    bram_arbiter #(.FIXED_PRIORITY(1'b1)) u_fp (
        .clk(clk), .reset(reset),
        .m0_req(freq[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_we(we[0]), .m0_mask(mask[0]),
        .m0_gnt(fgnt[0]), .m0_rvalid(frvalid[0]), .m0_rdata(frdata[0]), .m0_err(ferr[0]),
        .m1_req(freq[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_we(we[1]), .m1_mask(mask[1]),
        .m1_gnt(fgnt[1]), .m1_rvalid(frvalid[1]), .m1_rdata(frdata[1]), .m1_err(ferr[1]),
        .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_write(fmem_write),
        .mem_mask(fmem_mask), .mem_rdata(fmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // BRAM model: registered read, byte-masked write
    always @(posedge clk) begin
        if (mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) bram[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= bram[mem_addr[8:2]];
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        ent_t        e;
        logic        oob;
        logic [31:0] exp_d;
        if (reset) begin
            sb.delete();
        end else begin
            chk("gnt_onehot", 32'(gnt == 2'b11), 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (rvalid[p]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rvalid", 32'(p), 32'hffff_ffff);
                    end else begin
                        e     = sb.pop_front();
                        oob   = e.addr > 32'h1ff;
                        exp_d = (!e.we && !oob) ? ref_mem[e.addr[8:2]] : 32'h0;
                        chk("rv_port", 32'(p), 32'(e.port));
                        chk("rv_latency", 32'(cyc - e.cyc), 32'd2);
                        chk("rdata", rdata[p], exp_d);
                        chk("err", 32'(err[p]), 32'(oob));
                        if (e.we && !oob)
                            for (int b = 0; b < 4; b++)
                                if (e.mask[b]) ref_mem[e.addr[8:2]][8*b +: 8] = e.wdata[8*b +: 8];
                        last_rdata = rdata[p];
                        last_err   = err[p];
                    end
                end
            end
            if (mem_write) begin
                nwr++;
                last_waddr = mem_addr;
            end
            for (int p = 0; p < 2; p++)
                if (gnt[p]) begin
                    sb.push_back('{p, cyc, addr[p], wdata[p], we[p], mask[p]});
                    glog.push_back(p);
                end
            if (fgnt[0]) fn0++;
            if (fgnt[1]) fn1++;
            if (frvalid[0]) frv0++;
            if (frvalid[1]) frv1++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
        bit ok = 0;
        @(posedge clk); #1;
        req[p] = 1'b1; addr[p] = a; wdata[p] = d; we[p] = w; mask[p] = m;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (gnt[p]) ok = 1;
        end
        if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        logic [31:0] b0;
        for (int i = 0; i < 128; i++) begin bram[i] = '0; ref_mem[i] = '0; end
        for (int p = 0; p < 2; p++) begin addr[p] = '0; wdata[p] = '0; we[p] = 0; mask[p] = '0; end
        reset = 1'b1;
        req[0] = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        idle(2);
        req[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_mask", 32'(mem_mask), 32'h0);
        chk("rst_rdata0", rdata[0], 32'h0);

        // 1: full write then read
        n = nwr;
        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111);
        idle(3);
        chk("t1_write_pulses", 32'(nwr - n), 32'd1);
        chk("t1_write_addr", last_waddr, 32'h10);
        txn(0, 0, 32'h10, 32'h0, 4'b0000);
        idle(3);
        chk("t1_read", last_rdata, 32'hDEADBEEF);

        // 2: partial write
        txn(0, 1, 32'h14, 32'h11223344, 4'b1111);
        txn(0, 1, 32'h14, 32'h0000AB00, 4'b0010);
        txn(1, 0, 32'h14, 32'h0, 4'b1111);
        idle(3);
        chk("t2_partial", last_rdata, 32'h1122AB44);

        // 3: round-robin with both requesting continuously
        do_reset();
        glog.delete();
        addr[0] = 32'h10; we[0] = 0; mask[0] = 4'hf;
        addr[1] = 32'h14; we[1] = 0; mask[1] = 4'hf;
        req = 2'b11;
        idle(9);
        req = 2'b00;
        idle(4);
        chk("t3_grant_count_ge4", 32'(glog.size() >= 4), 32'd1);
        for (int i = 0; i < glog.size() && i < 4; i++)
            chk($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(i % 2));

        // 4: fixed priority
        do_reset();
        fn0 = 0; fn1 = 0; frv0 = 0; frv1 = 0;
        freq = 2'b11;
        repeat (8) @(negedge clk);
        chk("t4_m0_grants", 32'(fn0), 32'd4);
        chk("t4_m1_starved", 32'(fn1), 32'd0);
        @(posedge clk); #1;
        freq[0] = 1'b0;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (fgnt[1]) ok = 1;
        end
        chk("t4_m1_granted", 32'(ok), 32'd1);
        @(posedge clk); #1;
        freq[1] = 1'b0;
        idle(4);
        chk("t4_m1_grants", 32'(fn1), 32'd1);
        chk("t4_m0_rvalids", 32'(frv0), 32'd4);
        chk("t4_m1_rvalids", 32'(frv1), 32'd1);

        // 5: out-of-window write
        txn(0, 1, 32'h0, 32'h01020304, 4'b1111);
        idle(3);
        b0 = bram[0];
        n = nwr;
        txn(1, 1, 32'h400, 32'hCAFEF00D, 4'b1111);
        idle(3);
        chk("t5_no_write", 32'(nwr - n), 32'd0);
        chk("t5_err", 32'(last_err), 32'd1);
        chk("t5_rdata", last_rdata, 32'h0);
        chk("t5_bram_kept", bram[0], b0);
        chk("t5_bram_val", b0, ref_mem[0]);

        // 6: reset during ACCESS of a write
        txn(0, 1, 32'h20, 32'h55AA55AA, 4'b1111);
        idle(3);
        txn(0, 1, 32'h20, 32'h12345678, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_write_suppressed", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t6_no_rvalid", 32'(rvalid), 32'd0);
        idle(3);
        txn(0, 0, 32'h20, 32'h0, 4'b0000);
        idle(3);
        chk("t6_old_value", last_rdata, 32'h55AA55AA);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
